bcd_counter_scan: RTL
=====================

Name: bcd_counter_scan

Overview:
- Parametrised multi-digit BCD up/down counter with parallel load, enable, terminal-count flag and load-error detection.
- Includes a time-multiplexed 7-segment display driver: active-low segments, one shared segment bus, active-low digit enables.
- Next-generation replacement for the single-digit load/count + decoder block; sits between board switches/control logic and the seven-segment display pins.

Parameters:
- DIGITS, 4, number of BCD decades (1..8); count width is 4*DIGITS.
- SCAN_DIV, 1000, clk cycles each digit is displayed before the scan advances (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- load  in  1  parallel load strobe; has priority over en.
- en  in  1  count enable.
- up  in  1  direction: 1 = up, 0 = down; sampled only when en=1.
- data  in  4*DIGITS  load value, digit 0 in bits [3:0].
- count  out  4*DIGITS  registered BCD count, digit 0 = least significant.
- tc  out  1  combinational terminal count: en & ~load & (up ? all digits 9 : all digits 0).
- load_err  out  1  registered, one-cycle pulse after a load that contained any nibble > 9.
- seg  out  8  registered active-low segments {dp,g,f,e,d,c,b,a}; dp always 1.
- an  out  DIGITS  registered active-low digit enable; one-hot-low after the first clock.

Behaviour:
- Reset (async, rst=1): count=0, load_err=0, seg=8'hFF (blank), an=all ones, prescaler=0, scan index=0.
- Per clk edge, priority order: load, then en, else hold.
- Load:
  - count <= data nibble-wise; any nibble > 9 is stored as 0.
  - load_err <= 1 if any nibble was > 9; otherwise load_err is 0 every cycle.
- Count up (en=1, up=1):
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - All 9s wraps to all 0s in the same cycle tc=1.
- Count down (en=1, up=0):
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All 0s wraps to all 9s with tc=1.
- Carry/borrow ripples combinationally through all decades within one cycle; count latency from enable is one clock.
- Prescaler:
  - Free-running 0..SCAN_DIV-1, independent of load/en.
  - On reaching SCAN_DIV-1 it returns to 0 and the scan index advances; index wraps from DIGITS-1 to 0.
- Display outputs, updated every clock:
  - an <= ~(1 << index).
  - seg <= decode(count digit[index]), using the registered count.
  - seg therefore lags a count change by one cycle.
- Decode (hex, active-low): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, other FF.
- rst asserted mid-scan or mid-count: all state clears immediately; scanning restarts at digit 0 on the first clock after release.
- load and en both high: load wins, no count step that cycle, tc=0.
- DIGITS=1: index is held at 0 and an is constantly 0 after the first clock.

Decomposition:
- Shared package bcd_pkg holds:
  - segment constants SEG_0..SEG_9 and SEG_BLANK;
  - function bcd_to_seg (4-bit in, 8-bit out);
  - BCD_MAX = 4'd9.
- Sub-module bcd_digit: one decade with ports d, up, cin, q_next, cout; cin means carry or borrow according to up. Instantiate it DIGITS times in a generate chain.
- Prescaler, scan index and output registers stay in the top level.

Test Plan:
- Reset: rst=1 mid-run -> count=0, seg=FF, an=1111 immediately, no clock needed; release, 1 clk -> an=1110, seg=C0.
- Up wrap (DIGITS=4): load 0x9998, en=1, up=1, 2 clks -> count 0x9999, then 0x0000. tc=1 only during the cycle count=0x9999; carry across all four decades is correct.
- Down borrow: load 0x1000, en=1, up=0, 1 clk -> count 0x0999. Then load 0x0000, 1 clk with en=1, up=0 -> count 0x9999 with tc=1 beforehand.
- Invalid load: data=0x3A5F -> count 0x3050, load_err=1 for exactly one cycle. Next load of 0x1234 -> load_err=0.
- Priority/hold: load=1, en=1, data=0x0042 -> count 0x0042, tc=0. en=0 for 10 clks -> count stays 0x0042.
- Scan (SCAN_DIV=3, count 0x4321): an sequence 1110,1101,1011,0111, each held 3 clks, with seg F9,A4,B0,99 respectively, then wrap to 1110.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants and the active-low 7-segment decode used by the counter/scan block.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Segment order {dp,g,f,e,d,c,b,a}, active-low, dp always off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade step: combinational increment/decrement with carry/borrow in and out.
// cin is a carry when up=1 and a borrow when up=0; with cin=0 the digit passes through.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] q_next,
  output logic       cout
);

  always_comb begin
    q_next = d;
    cout   = 1'b0;
    if (cin) begin
      if (up) begin
        if (d >= BCD_MAX) begin
          q_next = 4'd0;
          cout   = 1'b1;
        end else begin
          q_next = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          q_next = BCD_MAX;
          cout   = 1'b1;
        end else begin
          q_next = d - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter_scan.sv
// Multi-decade BCD up/down counter with sanitising parallel load and a
// time-multiplexed active-low 7-segment scan driver.
module bcd_counter_scan
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  en,
  input  logic                  up,
  input  logic [4*DIGITS-1:0]   data,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  load_err,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW   = $clog2(SCAN_DIV);

  logic [W-1:0]      count_q, count_d;
  logic              load_err_q, load_err_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  logic [W-1:0]      step;
  logic [DIGITS:0]   carry;
  logic [W-1:0]      load_val;
  logic              load_bad;
  logic              presc_wrap;
  logic [3:0]        cur_digit;

  // Chain always requests a step; the final carry-out therefore means every
  // decade was at its terminal value (all 9 up, all 0 down).
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .d      (count_q[4*g +: 4]),
      .up     (up),
      .cin    (carry[g]),
      .q_next (step[4*g +: 4]),
      .cout   (carry[g+1])
    );
  end

  always_comb begin
    load_val = '0;
    load_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (data[4*i +: 4] > BCD_MAX) begin
        load_bad = 1'b1;
      end else begin
        load_val[4*i +: 4] = data[4*i +: 4];
      end
    end
  end

  always_comb begin
    count_d    = count_q;
    load_err_d = 1'b0;
    if (load) begin
      count_d    = load_val;
      load_err_d = load_bad;
    end else if (en) begin
      count_d = step;
    end
  end

  assign tc = en & ~load & carry[DIGITS];

  always_comb begin
    presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
    presc_d    = presc_wrap ? '0 : presc_q + PW'(1);
    idx_d      = idx_q;
    if (DIGITS == 1) begin
      idx_d = '0;
    end else if (presc_wrap) begin
      idx_d = (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + IDXW'(1);
    end
  end

  // Display uses the registered count, so seg trails a count change by a cycle.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDXW'(i) == idx_q) begin
        cur_digit = count_q[4*i +: 4];
      end
    end
    seg_d = bcd_to_seg(cur_digit);
    an_d  = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      load_err_q <= 1'b0;
      seg_q      <= SEG_BLANK;
      an_q       <= '1;
      presc_q    <= '0;
      idx_q      <= '0;
    end else begin
      count_q    <= count_d;
      load_err_q <= load_err_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
    end
  end

  assign count    = count_q;
  assign load_err = load_err_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule
